// File: rtl/multdiv_pkg.sv
// Shared encodings for the mult/div sequencer, main control and HI/LO muxes.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package multdiv_pkg;

  // Sequencer state encoding; main control decodes these values directly.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MULT_RUN = 3'd1,
    DIV_RUN  = 3'd2,
    WB       = 3'd3,
    DIV0     = 3'd4
  } mdstate_t;

  // HI/LO mux select values: which unit's result is written back.
  localparam logic SEL_MULT = 1'b0;
  localparam logic SEL_DIV  = 1'b1;

endpackage

// File: rtl/multdiv_ctrl_counter.sv
// Loadable down-counter with zero flag; stops at zero and never wraps.
// Latency: load/clear/decrement take effect on the next rising edge.
// Backpressure: none; the owner decides when to decrement.
module cycle_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             clear,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  // Clear beats load beats decrement; decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer: starts mult/div, counts fixed latency, then one HI/LO write-back cycle.
// Latency: accept at edge E -> RUN E+1..E+N, write-back E+N+1, idle again at E+N+2.
// Backpressure: busy stalls main control; requests are only sampled while idle.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic clk,
  input  logic reset_n,
  input  logic multReq,
  input  logic divReq,
  input  logic divisorZero,
  input  logic flush,
  output logic multStart,
  output logic divStart,
  output logic Hicontrol,
  output logic Locontrol,
  output logic HIwrite,
  output logic LOwrite,
  output logic busy,
  output logic div0Exc,
  output logic opDone
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  mdstate_t         state, state_nxt;
  logic             op, op_nxt;
  logic             cnt_load, cnt_clear, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val, cnt;

  cycle_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .clear    (cnt_clear),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // State and result-select registers; op holds its value outside RUN/WB.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      op    <= SEL_MULT;
    end else begin
      state <= state_nxt;
      op    <= op_nxt;
    end
  end

  // Next-state and counter control; flush wins over requests in IDLE.
  always_comb begin
    state_nxt    = state;
    op_nxt       = op;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_clear    = 1'b0;
    cnt_dec      = 1'b0;
    case (state)
      IDLE: begin
        if (!flush) begin
          if (multReq) begin
            state_nxt    = MULT_RUN;
            op_nxt       = SEL_MULT;
            cnt_load     = 1'b1;
            cnt_load_val = MULT_LOAD;
          end else if (divReq && !divisorZero) begin
            state_nxt    = DIV_RUN;
            op_nxt       = SEL_DIV;
            cnt_load     = 1'b1;
            cnt_load_val = DIV_LOAD;
          end else if (divReq) begin
            state_nxt = DIV0;
          end
        end
      end
      MULT_RUN, DIV_RUN: begin
        if (flush) begin
          state_nxt = IDLE;
          cnt_clear = 1'b1;
        end else if (cnt_zero) begin
          state_nxt = WB;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      WB:      state_nxt = IDLE;
      DIV0:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Start pulses fire only while the counter still holds its loaded value.
  assign multStart = (state == MULT_RUN) && (cnt == MULT_LOAD);
  assign divStart  = (state == DIV_RUN)  && (cnt == DIV_LOAD);
  assign Hicontrol = op;
  assign Locontrol = op;
  assign HIwrite   = (state == WB);
  assign LOwrite   = (state == WB);
  assign opDone    = (state == WB);
  assign div0Exc   = (state == DIV0);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: directed table, latency sequences, random run.
// Latency: outputs compared on the falling edge after each rising edge.
// Backpressure: every wait on the DUT is bounded by a cycle budget.
module tb_multdiv_ctrl;

  localparam int MC = 32;
  localparam int DC = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, multReq, divReq, divisorZero, flush;
  logic multStart, divStart, Hicontrol, Locontrol, HIwrite, LOwrite, busy, div0Exc, opDone;

  multdiv_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(6)) dut (
    .clk(clk), .reset_n(reset_n), .multReq(multReq), .divReq(divReq),
    .divisorZero(divisorZero), .flush(flush), .multStart(multStart),
    .divStart(divStart), .Hicontrol(Hicontrol), .Locontrol(Locontrol),
    .HIwrite(HIwrite), .LOwrite(LOwrite), .busy(busy), .div0Exc(div0Exc),
    .opDone(opDone)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: which operation is in flight and how many cycles since accept.
  int   m_kind = 0;   // 0 none, 1 mult, 2 div, 3 divide-by-zero
  int   m_k    = 0;   // 1 = first cycle after the accepting edge
  logic m_sel  = 1'b0;

  // Output order: multStart divStart Hicontrol Locontrol HIwrite LOwrite busy div0Exc opDone
  function automatic logic [8:0] model_out();
    logic ms, ds, wb, bz, d0;
    int n;
    ms = 0; ds = 0; wb = 0; bz = 0; d0 = 0;
    n = (m_kind == 1) ? MC : DC;
    if (m_kind == 1 || m_kind == 2) begin
      bz = 1;
      if (m_k == 1) begin
        if (m_kind == 1) ms = 1; else ds = 1;
      end
      if (m_k == n + 1) wb = 1;
    end else if (m_kind == 3) begin
      bz = 1;
      d0 = 1;
    end
    return {ms, ds, m_sel, m_sel, wb, wb, bz, d0, wb};
  endfunction

  task automatic model_edge();
    int last;
    if (!reset_n) begin
      m_kind = 0; m_k = 0; m_sel = 1'b0;
    end else if (m_kind == 0) begin
      if (!flush) begin
        if (multReq) begin
          m_kind = 1; m_k = 1; m_sel = 1'b0;
        end else if (divReq && divisorZero) begin
          m_kind = 3; m_k = 1;
        end else if (divReq) begin
          m_kind = 2; m_k = 1; m_sel = 1'b1;
        end
      end
    end else begin
      last = (m_kind == 3) ? 1 : ((m_kind == 1) ? MC + 1 : DC + 1);
      if (m_kind != 3 && flush && m_k <= last - 1) m_kind = 0;
      else if (m_k == last) m_kind = 0;
      else m_k = m_k + 1;
    end
  endtask

  function automatic logic [8:0] dut_out();
    return {multStart, divStart, Hicontrol, Locontrol, HIwrite, LOwrite, busy, div0Exc, opDone};
  endfunction

  task automatic check(input string name, input logic [8:0] exp);
    logic [8:0] got;
    got = dut_out();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step(input string name);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check({name, "/model"}, model_out());
  endtask

  task automatic drive(input logic r, input logic m, input logic d, input logic z, input logic f);
    reset_n = r; multReq = m; divReq = d; divisorZero = z; flush = f;
  endtask

  // Steps until opDone, returning cycles elapsed; -1 if the budget runs out.
  task automatic wait_done(input string name, input int budget, output int cycles);
    cycles = -1;
    for (int i = 1; i <= budget; i++) begin
      step(name);
      if (opDone === 1'b1) begin
        cycles = i;
        break;
      end
    end
    n_checks++;
    if (cycles < 0) begin
      n_fail++;
      $display("FAIL %s_timeout: got no opDone within %0d cycles", name, budget);
    end
  endtask

  typedef struct {
    string      name;
    logic       rst_n, mreq, dreq, dz, fl;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[12];
  int   lat;
  bit   saw_bad;

  initial begin
    tbl[0]  = '{"reset",        0, 0, 0, 0, 0, 9'b000000000};
    tbl[1]  = '{"idle",         1, 0, 0, 0, 0, 9'b000000000};
    tbl[2]  = '{"mult_accept",  1, 1, 0, 0, 0, 9'b100000100};
    tbl[3]  = '{"mult_ignore",  1, 1, 0, 0, 0, 9'b000000100};
    tbl[4]  = '{"run_flush",    1, 0, 0, 0, 1, 9'b000000000};
    tbl[5]  = '{"div_accept",   1, 0, 1, 0, 0, 9'b011100100};
    tbl[6]  = '{"div_run",      1, 0, 0, 0, 0, 9'b001100100};
    tbl[7]  = '{"div_flush",    1, 0, 0, 0, 1, 9'b001100000};
    tbl[8]  = '{"div0",         1, 0, 1, 1, 0, 9'b001100110};
    tbl[9]  = '{"idle_flush",   1, 0, 1, 0, 1, 9'b001100000};
    tbl[10] = '{"both_req",     1, 1, 1, 0, 0, 9'b100000100};
    tbl[11] = '{"reset_in_run", 0, 0, 0, 0, 0, 9'b000000000};

    // Reset held 3 cycles, then 10 quiet idle cycles.
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("reset_hold");
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step("idle_after_reset");
      check("idle_after_reset", 9'b000000000);
    end

    // Directed table: one cycle per record.
    foreach (tbl[i]) begin
      drive(tbl[i].rst_n, tbl[i].mreq, tbl[i].dreq, tbl[i].dz, tbl[i].fl);
      step(tbl[i].name);
      check(tbl[i].name, tbl[i].exp);
    end

    // Full mult latency: write-back in the 33rd cycle after accept, then idle.
    drive(1, 1, 0, 0, 0);
    step("mult_full_accept");
    drive(1, 0, 0, 0, 0);
    wait_done("mult_full", 100, lat);
    n_checks++;
    if (lat + 1 != MC + 1) begin
      n_fail++;
      $display("FAIL mult_latency: got %0d expected %0d", lat + 1, MC + 1);
    end
    check("mult_wb", 9'b000011101);
    step("mult_after_wb");
    check("mult_after_wb", 9'b000000000);

    // Div with a mult request held throughout; mult accepted only after idle.
    drive(1, 0, 1, 0, 0);
    step("div_full_accept");
    drive(1, 1, 0, 0, 0);
    wait_done("div_full", 100, lat);
    n_checks++;
    if (lat + 1 != DC + 1) begin
      n_fail++;
      $display("FAIL div_latency: got %0d expected %0d", lat + 1, DC + 1);
    end
    check("div_wb", 9'b001111101);
    step("div_then_idle");
    check("div_then_idle", 9'b001100000);
    step("held_mult_accept");
    check("held_mult_accept", 9'b100000100);
    drive(1, 0, 0, 0, 0);
    wait_done("held_mult", 100, lat);

    // Divide by zero: single exception cycle, no start or write.
    step("pre_div0");
    drive(1, 0, 1, 1, 0);
    step("div0_accept");
    check("div0_accept", 9'b000000110);
    drive(1, 0, 0, 0, 0);
    step("div0_after");
    check("div0_after", 9'b000000000);

    // Mult flushed 10 cycles in, then reset in the middle of a div run.
    drive(1, 1, 0, 0, 0);
    step("flush_accept");
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) step("flush_run");
    drive(1, 0, 0, 0, 1);
    step("flush_hit");
    check("flush_hit", 9'b000000000);
    drive(1, 0, 1, 0, 0);
    step("div_for_reset");
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("div_for_reset_run");
    drive(0, 0, 0, 0, 0);
    step("reset_mid_div");
    check("reset_mid_div", 9'b000000000);
    drive(1, 0, 0, 0, 0);
    saw_bad = 0;
    for (int i = 0; i < 40; i++) begin
      step("post_reset_quiet");
      if (HIwrite || opDone || busy) saw_bad = 1;
    end
    n_checks++;
    if (saw_bad) begin
      n_fail++;
      $display("FAIL post_reset_quiet: got write-back/busy after reset expected none");
    end

    // Randomised traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 59) == 0));
      step("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
Multi-cycle sequencer for the mult and div units and the HI/LO register write path. It accepts one mult or div request from the main control unit and pulses the selected unit's start. It counts the unit's fixed latency, then drives Hicontrol/Locontrol and the HIwrite/LOwrite enables for a single write-back cycle. It also raises the divide-by-zero exception and holds busy so the main control unit stalls.

Parameters:
MULT_CYCLES, 32, cycles the mult unit needs after its start pulse (>=1)
DIV_CYCLES, 32, cycles the div unit needs after its start pulse (>=1)
CNT_W, 6, counter width; must hold max(MULT_CYCLES,DIV_CYCLES)-1

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  synchronous, active-low reset
multReq  input  1  request mult; level, sampled only in IDLE
divReq  input  1  request div; level, sampled only in IDLE
divisorZero  input  1  divisor==0 flag from datapath; sampled with divReq
flush  input  1  abort the in-flight operation (exception/branch squash)
multStart  output  1  one-cycle start pulse to the mult unit
divStart  output  1  one-cycle start pulse to the div unit
Hicontrol  output  1  HI mux select: 0=mult, 1=div
Locontrol  output  1  LO mux select: 0=mult, 1=div
HIwrite  output  1  HI register write enable
LOwrite  output  1  LO register write enable
busy  output  1  operation in flight; main control stalls
div0Exc  output  1  one-cycle divide-by-zero exception pulse
opDone  output  1  one-cycle pulse in the write-back cycle

Behaviour:
- Reset (reset_n=0 at a rising edge): state IDLE, counter 0, all outputs 0, Hicontrol=Locontrol=0. Reset overrides any operation in flight, with no write-back.
- States: IDLE, MULT_RUN, DIV_RUN, WB, DIV0. State bits and the counter are registered; outputs are decoded from state.
- IDLE, request accepted at edge E:
  - multReq=1 -> MULT_RUN, counter <= MULT_CYCLES-1, op <= 0.
  - else divReq=1 and divisorZero=0 -> DIV_RUN, counter <= DIV_CYCLES-1, op <= 1.
  - else divReq=1 and divisorZero=1 -> DIV0.
- Simultaneous multReq and divReq: mult wins; div is dropped and not queued.
- MULT_RUN/DIV_RUN:
  - multStart (resp. divStart) is 1 only in the first RUN cycle, i.e. when counter == its loaded value.
  - Counter decrements each cycle; at counter==0 -> WB next edge.
  - Total RUN length is exactly N cycles.
- WB (one cycle): HIwrite=LOwrite=1, opDone=1, then IDLE.
- Hicontrol=Locontrol=op from the first RUN cycle through WB. Both hold their last value in IDLE and DIV0.
- DIV0 (one cycle): div0Exc=1; no start pulse, no HI/LO write, opDone=0; then IDLE.
- busy=1 in MULT_RUN, DIV_RUN, WB and DIV0; 0 only in IDLE.
- Requests while busy=1 are ignored. They are accepted only in IDLE, so the earliest back-to-back accept is the cycle after WB.
- Latency: request accepted at edge E -> RUN cycles E+1..E+N, WB cycle E+N+1, IDLE at E+N+2.
- flush:
  - In RUN: -> IDLE next edge; no WB, no opDone, counter cleared. A start pulse already issued is not recalled.
  - In WB: the write still completes.
  - In IDLE: flush has priority over requests; no accept.
  - In DIV0: div0Exc still pulses.
- Counter never wraps: it is loaded only on accept and stops at 0.

Decomposition:
- Shared package multdiv_pkg: state encoding constants (IDLE=0, MULT_RUN=1, DIV_RUN=2, WB=3, DIV0=4, 3 bits) and op select constants (SEL_MULT=0, SEL_DIV=1). These are shared with the main control unit and mux_HI/LO instantiation.
- Natural sub-module: cycle_counter (loadable down-counter with zero flag, CNT_W wide).
- All else is a single FSM in multdiv_ctrl.

Test Plan:
1. Reset held 3 cycles then released, no requests -> all outputs 0, busy=0 for 10 cycles.
2. multReq=1 for one cycle at edge E (MULT_CYCLES=32) -> multStart=1 only at E+1; busy=1 for E+1..E+33; HIwrite=LOwrite=opDone=1 only at E+33 with Hicontrol=Locontrol=0; busy=0 at E+34.
3. divReq=1, divisorZero=0 at E (DIV_CYCLES=32) -> divStart at E+1; Hicontrol=1 from E+1; write-back at E+33; a multReq held during E+1..E+33 is ignored until E+34, then accepted.
4. divReq=1, divisorZero=1 at E -> div0Exc=1 and busy=1 at E+1 only; divStart, HIwrite and LOwrite never asserted.
5. multReq=divReq=1 at E -> mult path only: multStart at E+1, divStart never; Hicontrol=0 at write-back.
6. mult accepted at E, flush=1 at E+10 -> IDLE at E+11, busy=0, no HIwrite/opDone; then reset_n=0 during a DIV_RUN -> next cycle IDLE with all outputs 0, no write-back.
